// File: rtl/cmprs_page_fifo.sv
// Page-organised single-clock buffer with page commit/release accounting and 2-stage read pipeline.
// Optional sticky overflow/underflow flags enabled by defining CMPRS_PAGE_FIFO_ERR_EN.
module cmprs_page_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int LOG2_PAGES = 2,
  parameter int LOG2_DEPTH = 7
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  buf_reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  page_next,
  input  logic                  rd,
  input  logic                  page_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  dout_valid,
  output logic                  wr_ready,
  output logic                  rd_ready,
  output logic [LOG2_PAGES:0]   pages_full,
  output logic                  err_wr_full,
  output logic                  err_rd_empty
);

  localparam int ADDR_W    = LOG2_PAGES + LOG2_DEPTH;
  localparam int MEM_WORDS = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] ram_rdata_q;

  logic [LOG2_PAGES-1:0] wpage_q, wpage_d, rpage_q, rpage_d;
  logic [LOG2_DEPTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [LOG2_PAGES:0]   pages_full_q, pages_full_d;
  logic                  rd_vld1_q, rd_vld1_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  wr_acc, rd_acc, next_acc, done_acc;

  // pages_full never exceeds NUM_PAGES, so its MSB alone marks the full state
  assign wr_ready = ~pages_full_q[LOG2_PAGES];
  assign rd_ready = |pages_full_q;

  assign wr_acc   = we        & wr_ready & ~buf_reset;
  assign next_acc = page_next & wr_ready & ~buf_reset;
  assign rd_acc   = rd        & rd_ready & ~buf_reset;
  assign done_acc = page_done & rd_ready & ~buf_reset;

  always_ff @(posedge mclk) begin
    if (wr_acc) mem[{wpage_q, waddr_q}] <= data_in;
    if (rd_acc) ram_rdata_q <= mem[{rpage_q, raddr_q}];
  end

  always_comb begin
    wpage_d      = wpage_q;
    waddr_d      = waddr_q;
    rpage_d      = rpage_q;
    raddr_d      = raddr_q;
    pages_full_d = pages_full_q;
    rd_vld1_d    = rd_acc;
    dout_valid_d = rd_vld1_q;
    data_out_d   = rd_vld1_q ? ram_rdata_q : data_out_q;

    if (wr_acc) waddr_d = waddr_q + LOG2_DEPTH'(1);
    if (rd_acc) raddr_d = raddr_q + LOG2_DEPTH'(1);
    // a commit/release in the same cycle as a word access still moves to the new page at addr 0
    if (next_acc) begin
      wpage_d = wpage_q + LOG2_PAGES'(1);
      waddr_d = '0;
    end
    if (done_acc) begin
      rpage_d = rpage_q + LOG2_PAGES'(1);
      raddr_d = '0;
    end
    case ({next_acc, done_acc})
      2'b10:   pages_full_d = pages_full_q + (LOG2_PAGES+1)'(1);
      2'b01:   pages_full_d = pages_full_q - (LOG2_PAGES+1)'(1);
      default: pages_full_d = pages_full_q;
    endcase

    if (buf_reset) begin
      wpage_d      = '0;
      waddr_d      = '0;
      rpage_d      = '0;
      raddr_d      = '0;
      pages_full_d = '0;
      rd_vld1_d    = 1'b0;
      dout_valid_d = 1'b0;
      data_out_d   = '0;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wpage_q      <= '0;
      waddr_q      <= '0;
      rpage_q      <= '0;
      raddr_q      <= '0;
      pages_full_q <= '0;
      rd_vld1_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      wpage_q      <= wpage_d;
      waddr_q      <= waddr_d;
      rpage_q      <= rpage_d;
      raddr_q      <= raddr_d;
      pages_full_q <= pages_full_d;
      rd_vld1_q    <= rd_vld1_d;
      dout_valid_q <= dout_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  assign data_out   = data_out_q;
  assign dout_valid = dout_valid_q;
  assign pages_full = pages_full_q;

`ifdef CMPRS_PAGE_FIFO_ERR_EN
  logic err_wr_full_q, err_wr_full_d, err_rd_empty_q, err_rd_empty_d;

  // flags survive buf_reset; only rst_n clears them
  always_comb begin
    err_wr_full_d  = err_wr_full_q  | ((we | page_next) & ~wr_ready & ~buf_reset);
    err_rd_empty_d = err_rd_empty_q | ((rd | page_done) & ~rd_ready & ~buf_reset);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      err_wr_full_q  <= 1'b0;
      err_rd_empty_q <= 1'b0;
    end else begin
      err_wr_full_q  <= err_wr_full_d;
      err_rd_empty_q <= err_rd_empty_d;
    end
  end

  assign err_wr_full  = err_wr_full_q;
  assign err_rd_empty = err_rd_empty_q;
`else
  assign err_wr_full  = 1'b0;
  assign err_rd_empty = 1'b0;
`endif

endmodule
